// File: rtl/cla_addsub_pipe.sv
// Two-stage elastic add/subtract unit built on a Kogge-Stone prefix carry network.
// Stage 1 registers bitwise generate/propagate; stage 2 resolves carries and flags.
module cla_addsub_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int LEVELS = $clog2(WIDTH);

  // Group generate G[i:0] for every bit position via log2(WIDTH) combine levels.
  function automatic logic [WIDTH-1:0] prefix_generate(input logic [WIDTH-1:0] g_in,
                                                       input logic [WIDTH-1:0] p_in);
    logic [WIDTH-1:0] g_cur, p_cur, g_nxt, p_nxt;
    g_cur = g_in;
    p_cur = p_in;
    for (int l = 0; l < LEVELS; l++) begin
      g_nxt = g_cur;
      p_nxt = p_cur;
      for (int i = (1 << l); i < WIDTH; i++) begin
        g_nxt[i] = g_cur[i] | (p_cur[i] & g_cur[i - (1 << l)]);
        p_nxt[i] = p_cur[i] & p_cur[i - (1 << l)];
      end
      g_cur = g_nxt;
      p_cur = p_nxt;
    end
    return g_cur;
  endfunction

  logic             vld_p1, vld_p2;
  logic             s2_load, advance, accept;
  logic [WIDTH-1:0] bb_in;

  logic [WIDTH-1:0] p_p1, g_p1;
  logic             cin_p1, a_msb_p1, bb_msb_p1;

  logic [WIDTH-1:0] result_p2;
  logic             carry_p2, ovf_p2, zero_p2;

  logic [WIDTH-1:0] g_fold, grp_g, carry_vec, sum_s2;
  logic             ovf_s2;

  assign s2_load  = !vld_p2 || out_ready;
  assign advance  = vld_p1 && s2_load;
  assign in_ready = !vld_p1 || s2_load;
  assign accept   = in_valid && in_ready;

  assign bb_in = sub ? ~b : b;

  // ---- stage 1: operand conditioning and bitwise generate/propagate ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      p_p1      <= '0;
      g_p1      <= '0;
      cin_p1    <= 1'b0;
      a_msb_p1  <= 1'b0;
      bb_msb_p1 <= 1'b0;
    end else begin
      if (accept) begin
        p_p1      <= a ^ bb_in;
        g_p1      <= a & bb_in;
        cin_p1    <= sub;
        a_msb_p1  <= a[WIDTH-1];
        bb_msb_p1 <= bb_in[WIDTH-1];
      end
      vld_p1 <= accept || (vld_p1 && !advance);
    end
  end

  // Carry-in is folded into bit 0 so the tree needs no separate cin input.
  always_comb begin
    g_fold    = g_p1;
    g_fold[0] = g_p1[0] | (p_p1[0] & cin_p1);
    grp_g     = prefix_generate(g_fold, p_p1);
    carry_vec = {grp_g[WIDTH-2:0], cin_p1};
    sum_s2    = p_p1 ^ carry_vec;
    ovf_s2    = (a_msb_p1 == bb_msb_p1) && (sum_s2[WIDTH-1] != a_msb_p1);
  end

  // ---- stage 2: resolved sum and status flags ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2    <= 1'b0;
      result_p2 <= '0;
      carry_p2  <= 1'b0;
      ovf_p2    <= 1'b0;
      zero_p2   <= 1'b0;
    end else if (s2_load) begin
      vld_p2 <= advance;
      if (advance) begin
        result_p2 <= sum_s2;
        carry_p2  <= grp_g[WIDTH-1];
        ovf_p2    <= ovf_s2;
        zero_p2   <= ~|sum_s2;
      end
    end
  end

  assign out_valid = vld_p2;
  assign result    = result_p2;
  assign carry_out = carry_p2;
  assign overflow  = ovf_p2;
  assign zero      = zero_p2;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Directed bench for cla_addsub_pipe: corner arithmetic, streaming, stall and reset.
module tb_cla_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] a, b;
  logic        sub;
  logic        out_valid, out_ready;
  logic [15:0] result;
  logic        carry_out, overflow, zero;

  cla_addsub_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Hand-computed stream results: A=i, B=3i, odd i subtracts.
  logic [15:0] exp_res [8];
  int          rx_idx;
  logic        mon_en;
  int          first_out_cyc, last_out_cyc;
  logic        saw_in_ready_low;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (out_valid && out_ready) begin
        if (rx_idx < 8) check_eq($sformatf("stream_res%0d", rx_idx), result, exp_res[rx_idx]);
        else            check_eq("stream_extra", rx_idx, 7);
        if (rx_idx == 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
        rx_idx++;
      end else if (out_valid && !out_ready && rx_idx < 8) begin
        check_eq("stall_hold", result, exp_res[rx_idx]);
      end
    end
  end

  task automatic send_op(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                         input bit ready_required, output int acc_cyc);
    int  t;
    bit  done;
    t = 0;
    done = 0;
    acc_cyc = 0;
    in_valid = 1'b1;
    a = av;
    b = bv;
    sub = sv;
    while (!done && t < 50) begin
      @(negedge clk);
      acc_cyc = cyc;
      if (in_ready) done = 1;
      else saw_in_ready_low = 1'b1;
      if (ready_required) check_eq("in_ready_stream", in_ready, 1);
      @(posedge clk); #1;
      t++;
    end
    if (!done) check_eq("accept_timeout", t, 0);
    in_valid = 1'b0;
  endtask

  task automatic single_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                           input logic sv, input logic [15:0] er, input logic ec,
                           input logic eo, input logic ez);
    int ac;
    out_ready = 1'b1;
    send_op(av, bv, sv, 0, ac);
    @(posedge clk); #1;
    check_eq({tag, "_valid"}, out_valid, 1);
    check_eq({tag, "_result"}, result, er);
    check_eq({tag, "_carry"}, carry_out, ec);
    check_eq({tag, "_ovf"}, overflow, eo);
    check_eq({tag, "_zero"}, zero, ez);
    @(posedge clk); #1;
    check_eq({tag, "_drained"}, out_valid, 0);
  endtask

  task automatic wait_rx(input int n);
    int t;
    t = 0;
    while (rx_idx < n && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("rx_count", rx_idx, n);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc0, acc_tmp;
    exp_res[0] = 16'h0000; exp_res[1] = 16'hFFFE;
    exp_res[2] = 16'h0008; exp_res[3] = 16'hFFFA;
    exp_res[4] = 16'h0010; exp_res[5] = 16'hFFF6;
    exp_res[6] = 16'h0018; exp_res[7] = 16'hFFF2;
    rx_idx = 0; mon_en = 1'b0; saw_in_ready_low = 1'b0;
    first_out_cyc = 0; last_out_cyc = 0;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_result", result, 0);
    check_eq("rst_flags", {carry_out, overflow, zero}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    single_op("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    single_op("sub_0_1",    16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    single_op("sub_eq",     16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    single_op("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    single_op("sub_8000_1", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);

    // Back-to-back stream with the consumer always ready.
    out_ready = 1'b1;
    rx_idx = 0; mon_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_op(16'(i), 16'(3 * i), i[0], 1, acc_tmp);
      if (i == 0) acc0 = acc_tmp;
    end
    wait_rx(8);
    check_eq("stream_latency", first_out_cyc - acc0, 2);
    check_eq("stream_throughput", last_out_cyc - first_out_cyc, 7);

    // Same stream with a 4-cycle consumer stall mid-stream.
    rx_idx = 0; saw_in_ready_low = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_op(16'(i), 16'(3 * i), i[0], 0, acc_tmp);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_rx(8);
    check_eq("stall_backpressure", saw_in_ready_low, 1);
    mon_en = 1'b0;

    // Reset with two operations in flight.
    out_ready = 1'b0;
    send_op(16'h0001, 16'h0001, 1'b0, 0, acc_tmp);
    send_op(16'h0002, 16'h0002, 1'b0, 0, acc_tmp);
    check_eq("pre_reset_valid", out_valid, 1);
    check_eq("pre_reset_result", result, 16'h0002);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_in_ready", in_ready, 1);
    check_eq("mid_rst_result", result, 0);
    check_eq("mid_rst_flags", {carry_out, overflow, zero}, 0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("post_rst_no_stale", out_valid, 0);
    end
    @(posedge clk); #1;
    single_op("post_rst_add", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_addsub_pipe.md
Name: cla_addsub_pipe

Overview:
- Two-stage elastic add/subtract unit. Built on a parallel-prefix (Kogge-Stone) carry network that uses the generate/propagate combine operator.
- Provides the subtract direction alongside add, with a valid/ready handshake on both sides.
- Sits between operand-issue logic and result consumers in the arithmetic datapath.
- Throughput: one operation per cycle. Latency: 2 cycles when not stalled.

Parameters:
- WIDTH, 16, operand/result width in bits; any value >= 2. The prefix tree has ceil(log2(WIDTH)) levels.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand set on a/b/sub is valid
- in_ready  output  1  unit accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  0: A+B, 1: A-B
- out_valid  output  1  result fields are valid
- out_ready  input  1  consumer accepts result this cycle
- result  output  WIDTH  sum/difference, modulo 2^WIDTH
- carry_out  output  1  carry out of MSB; for sub, 1 = no borrow (A >= B unsigned)
- overflow  output  1  two's-complement signed overflow
- zero  output  1  result == 0

Behaviour:
- Arithmetic:
  - bb = sub ? ~b : b; cin = sub.
  - Full sum is a + bb + cin, WIDTH+1 bits. result is the low WIDTH bits; carry_out is bit WIDTH.
  - overflow = (a[MSB] == bb[MSB]) && (result[MSB] != a[MSB]).
- Stage 1 (on accept): register p = a ^ bb, g = a & bb, cin, a[MSB], bb[MSB]. Set s1_valid.
- Stage 2 (on advance):
  - Fold cin into bit 0: g0' = g0 | (p0 & cin).
  - Run the prefix tree with the combine operator: G = Ghi | (Phi & Glo); P = Phi & Plo.
  - Carries: c[0] = cin, c[i] = G[i-1:0]. result = p ^ c.
  - Register result, carry_out, overflow, zero. Set s2_valid.
- out_valid = s2_valid.
- Handshake:
  - s2 can load when !s2_valid || out_ready.
  - s1 advances into s2 when s1_valid && s2 can load.
  - in_ready = !s1_valid || (s2 can load). in_ready is combinationally dependent on out_ready; this is permitted.
  - A transfer occurs only when valid && ready on the same edge.
- Stall: while out_valid && !out_ready, result/carry_out/overflow/zero hold stable and out_valid stays 1. Stage 1 holds its contents. At most 2 operations are in flight; none are dropped or reordered.
- Simultaneous events:
  - Output drain, s1->s2 advance and new input accept may all occur in one edge; full throughput is sustained.
  - s1_valid clears only when it advances with no new accept in the same cycle.
- Drain: with in_valid low, s1 empties into s2 on the next edge on which s2 can load.
- Latency: an operation accepted at edge N appears with out_valid = 1 after edge N+1, provided out_ready was 1 or s2 was empty at that edge.
- Reset (rst_n low, asynchronous, any time):
  - s1_valid = s2_valid = 0, so out_valid = 0 and in_ready = 1 while in reset.
  - result = 0, carry_out = 0, overflow = 0, zero = 0; stage-1 registers = 0.
  - In-flight operations are discarded. No result is produced after reset deasserts unless new input is accepted.
- X handling: a/b/sub are ignored when in_valid = 0. Output data is don't-care when out_valid = 0, but must be 0 immediately after reset.

Test Plan:
- WIDTH=16, add 0x7FFF + 0x0001, out_ready=1 -> after 2 cycles: result=0x8000, carry_out=0, overflow=1, zero=0.
- sub 0x0000 - 0x0001 -> result=0xFFFF, carry_out=0 (borrow), overflow=0. Then sub 0x1234 - 0x1234 -> result=0x0000, carry_out=1, zero=1, overflow=0.
- add 0xFFFF + 0x0001 -> result=0x0000, carry_out=1, overflow=0, zero=1. Then sub 0x8000 - 0x0001 -> result=0x7FFF, carry_out=1, overflow=1.
- Stream 8 back-to-back ops (A=i, B=3i, alternating sub), out_ready=1 -> one result per cycle, in order, first result 2 cycles after first accept, in_ready constantly 1.
- Same stream with out_ready=0 for 4 cycles mid-stream -> in_ready drops after 2 ops are held, held output stays stable, all 8 results delivered in order with no loss or duplication.
- Assert rst_n low for 1 cycle with 2 ops in flight -> out_valid=0 and outputs=0 immediately; after release no stale results. The next accepted op (0x0003 + 0x0004) yields result=0x0007.
